// File: rtl/mole_pkg.sv
// Shared definitions for the mole array: per-channel FSM states, the base
// duration table and the default counter width.
package mole_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_HIT  = 2'd2,
        ST_MISS = 2'd3
    } mole_state_e;

    localparam int DEF_TIMER_W = 14;

    // Element [d] is the base duration in ms for difficulty d (0 is slowest).
    localparam logic [3:0][9:0] BASE_MS = {10'd250, 10'd500, 10'd750, 10'd1000};

    function automatic logic [15:0] mole_load(input logic [1:0] difficulty,
                                              input logic [2:0] moletime);
        return ({13'd0, moletime} + 16'd1) * {6'd0, BASE_MS[difficulty]};
    endfunction

endpackage

// File: rtl/mole_channel.sv
// One mole: IDLE/UP/HIT/MISS FSM with a ms down-counter; all outputs registered,
// hit/miss pulses appear one cycle after the sampled cause and last one cycle.
module mole_channel
    import mole_pkg::*;
#(
    parameter int TIMER_W = DEF_TIMER_W
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       enable_i,
    input  logic       tick_i,
    input  logic [1:0] difficulty_i,
    input  logic [2:0] moletime_i,
    input  logic       spawn_i,
    input  logic       molehit_i,
    output logic       omole_o,
    output logic       hit_pulse_o,
    output logic       miss_pulse_o
);

    mole_state_e        state_q;
    logic [TIMER_W-1:0] cnt_q;
    logic               omole_q;
    logic               hit_q;
    logic               miss_q;
    logic [TIMER_W-1:0] load_val;

    assign load_val = TIMER_W'(mole_load(difficulty_i, moletime_i));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            omole_q <= 1'b0;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
        end else begin
            hit_q  <= 1'b0;
            miss_q <= 1'b0;
            if (!enable_i) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                omole_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (spawn_i) begin
                            state_q <= ST_UP;
                            cnt_q   <= load_val;
                            omole_q <= 1'b1;
                        end
                    end
                    ST_UP: begin
                        // A hit takes priority over an expiry in the same cycle.
                        if (molehit_i) begin
                            state_q <= ST_HIT;
                            cnt_q   <= '0;
                            omole_q <= 1'b0;
                            hit_q   <= 1'b1;
                        end else if (tick_i) begin
                            if (cnt_q < TIMER_W'(2)) begin
                                state_q <= ST_MISS;
                                cnt_q   <= '0;
                                omole_q <= 1'b0;
                                miss_q  <= 1'b1;
                            end else begin
                                cnt_q <= cnt_q - TIMER_W'(1);
                            end
                        end
                    end
                    ST_HIT, ST_MISS: begin
                        // Stay down until the request is released, so a held
                        // spawn cannot re-raise the mole.
                        if (!spawn_i) begin
                            state_q <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        omole_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign omole_o      = omole_q;
    assign hit_pulse_o  = hit_q;
    assign miss_pulse_o = miss_q;

endmodule

// File: rtl/mole_array.sv
// Array of mole channels sharing a 1 ms prescaler; omole/pulses one cycle after
// sampled inputs, active_count one cycle behind omole; no backpressure.
module mole_array
    import mole_pkg::*;
#(
    parameter int NUM_MOLES = 8,
    parameter int TICK_DIV  = 100000,
    parameter int TIMER_W   = DEF_TIMER_W
) (
    input  logic                           CLK100MHZ,
    input  logic                           CPU_RESETN,
    input  logic                           enable,
    input  logic [1:0]                     difficulty,
    input  logic [2:0]                     moletime,
    input  logic [NUM_MOLES-1:0]           spawn,
    input  logic [NUM_MOLES-1:0]           molehit,
    output logic [NUM_MOLES-1:0]           omole,
    output logic [NUM_MOLES-1:0]           hit_pulse,
    output logic [NUM_MOLES-1:0]           miss_pulse,
    output logic [$clog2(NUM_MOLES+1)-1:0] active_count
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(NUM_MOLES + 1);

    logic [PW-1:0] presc_q;
    logic          tick;
    logic [CW-1:0] active_count_q;
    logic [CW-1:0] active_count_d;

    assign tick = enable && (presc_q == PW'(TICK_DIV - 1));

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            presc_q <= '0;
        end else if (!enable || tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_MOLES; g++) begin : g_ch
            mole_channel #(
                .TIMER_W(TIMER_W)
            ) u_ch (
                .clk_i       (CLK100MHZ),
                .rst_ni      (CPU_RESETN),
                .enable_i    (enable),
                .tick_i      (tick),
                .difficulty_i(difficulty),
                .moletime_i  (moletime),
                .spawn_i     (spawn[g]),
                .molehit_i   (molehit[g]),
                .omole_o     (omole[g]),
                .hit_pulse_o (hit_pulse[g]),
                .miss_pulse_o(miss_pulse[g])
            );
        end
    endgenerate

    always_comb begin
        active_count_d = '0;
        for (int i = 0; i < NUM_MOLES; i++) begin
            active_count_d = active_count_d + CW'(omole[i]);
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            active_count_q <= '0;
        end else begin
            active_count_q <= active_count_d;
        end
    end

    assign active_count = active_count_q;

endmodule

// File: tb/tb_mole_array.sv
// Self-checking bench for mole_array: fixed vector table, directed corner
// sequences and randomized traffic against a deadline-based reference model.
module tb_mole_array;

    localparam int NM = 8;
    localparam int TD = 2;
    localparam int TW = 14;
    localparam int CW = $clog2(NM + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [1:0]    difficulty;
    logic [2:0]    moletime;
    logic [NM-1:0] spawn;
    logic [NM-1:0] molehit;
    logic [NM-1:0] omole;
    logic [NM-1:0] hit_pulse;
    logic [NM-1:0] miss_pulse;
    logic [CW-1:0] active_count;

    mole_array #(
        .NUM_MOLES(NM),
        .TICK_DIV (TD),
        .TIMER_W  (TW)
    ) dut (
        .CLK100MHZ   (clk),
        .CPU_RESETN  (rst_n),
        .enable      (enable),
        .difficulty  (difficulty),
        .moletime    (moletime),
        .spawn       (spawn),
        .molehit     (molehit),
        .omole       (omole),
        .hit_pulse   (hit_pulse),
        .miss_pulse  (miss_pulse),
        .active_count(active_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: a mole is up until a hit or until the global tick count
    // reaches the deadline fixed when it was raised.
    bit            m_up    [NM];
    bit            m_latch [NM];
    longint        m_deadline [NM];
    longint        m_ticks;
    int            m_ecyc;
    logic [NM-1:0] e_omole, e_hit, e_miss;
    int            e_count;

    function automatic longint load_ms(input int d, input int m);
        return longint'((m + 1) * (1000 - 250 * d));
    endfunction

    function automatic bit model_tick();
        return enable && ((m_ecyc % TD) == TD - 1);
    endfunction

    function automatic bit will_miss(input int ch);
        return m_up[ch] && model_tick() && !molehit[ch] && (m_ticks + 1 == m_deadline[ch]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NM; i++) begin
            m_up[i] = 0; m_latch[i] = 0; m_deadline[i] = 0;
        end
        m_ticks = 0; m_ecyc = 0;
        e_omole = '0; e_hit = '0; e_miss = '0; e_count = 0;
    endtask

    task automatic model_step();
        bit tk;
        tk = model_tick();
        m_ecyc = enable ? m_ecyc + 1 : 0;
        if (tk) m_ticks++;
        e_count = $countones(e_omole);
        e_hit = '0; e_miss = '0;
        for (int i = 0; i < NM; i++) begin
            if (!enable) begin
                m_up[i] = 0; m_latch[i] = 0;
            end else if (m_up[i]) begin
                if (molehit[i]) begin
                    m_up[i] = 0; m_latch[i] = 1; e_hit[i] = 1'b1;
                end else if (tk && m_ticks == m_deadline[i]) begin
                    m_up[i] = 0; m_latch[i] = 1; e_miss[i] = 1'b1;
                end
            end else if (m_latch[i]) begin
                if (!spawn[i]) m_latch[i] = 0;
            end else if (spawn[i]) begin
                m_up[i] = 1;
                m_deadline[i] = m_ticks + load_ms(int'(difficulty), int'(moletime));
            end
            e_omole[i] = m_up[i];
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic compare_all();
        check("model_omole", 32'(omole), 32'(e_omole));
        check("model_hit", 32'(hit_pulse), 32'(e_hit));
        check("model_miss", 32'(miss_pulse), 32'(e_miss));
        check("model_count", 32'(active_count), 32'(e_count));
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        enable = 1'b0; difficulty = '0; moletime = '0; spawn = '0; molehit = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_omole", 32'(omole), 32'd0);
        check("reset_count", 32'(active_count), 32'd0);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic          en;
        logic [NM-1:0] sp;
        logic [NM-1:0] mh;
        logic [NM-1:0] x_om;
        logic [NM-1:0] x_hit;
        logic [CW-1:0] x_cnt;
    } vec_t;

    vec_t tbl [12];
    bit   found;
    int   t0;
    int   misses;

    initial begin
        do_reset();

        // Long moles (difficulty 0, moletime 0): no expiry inside the table.
        tbl[0]  = '{1'b1, 8'h01, 8'h00, 8'h01, 8'h00, 4'd0};
        tbl[1]  = '{1'b1, 8'h00, 8'h02, 8'h01, 8'h00, 4'd1};
        tbl[2]  = '{1'b1, 8'h00, 8'h01, 8'h00, 8'h01, 4'd1};
        tbl[3]  = '{1'b1, 8'h01, 8'h01, 8'h00, 8'h00, 4'd0};
        tbl[4]  = '{1'b1, 8'h01, 8'h00, 8'h00, 8'h00, 4'd0};
        tbl[5]  = '{1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 4'd0};
        tbl[6]  = '{1'b1, 8'h01, 8'h00, 8'h01, 8'h00, 4'd0};
        tbl[7]  = '{1'b1, 8'h81, 8'h00, 8'h81, 8'h00, 4'd1};
        tbl[8]  = '{1'b0, 8'h81, 8'h81, 8'h00, 8'h00, 4'd2};
        tbl[9]  = '{1'b1, 8'hFF, 8'h00, 8'hFF, 8'h00, 4'd0};
        tbl[10] = '{1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF, 4'd8};
        tbl[11] = '{1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 4'd0};
        for (int r = 0; r < 12; r++) begin
            enable = tbl[r].en; spawn = tbl[r].sp; molehit = tbl[r].mh;
            step();
            check($sformatf("tbl%0d_omole", r), 32'(omole), 32'(tbl[r].x_om));
            check($sformatf("tbl%0d_hit", r), 32'(hit_pulse), 32'(tbl[r].x_hit));
            check($sformatf("tbl%0d_miss", r), 32'(miss_pulse), 32'd0);
            check($sformatf("tbl%0d_count", r), 32'(active_count), 32'(tbl[r].x_cnt));
        end

        // Timeout of a 250 ms mole.
        do_reset();
        enable = 1'b1; difficulty = 2'd3; moletime = 3'd0; spawn = 8'h01;
        step();
        check("timeout_up", 32'(omole[0]), 32'd1);
        t0 = cyc; spawn = '0; found = 0;
        for (int k = 0; k < 600; k++) begin
            step();
            if (miss_pulse[0]) begin found = 1; break; end
        end
        check("timeout_seen", 32'(found), 32'd1);
        check("timeout_window", 32'((cyc - t0) >= 498 && (cyc - t0) <= 502), 32'd1);
        check("timeout_down", 32'(omole[0]), 32'd0);

        // Hit ten cycles after raising.
        do_reset();
        enable = 1'b1; difficulty = 2'd1; moletime = 3'd2; spawn = 8'h04;
        step();
        spawn = '0;
        repeat (9) step();
        molehit = 8'h04;
        step();
        check("hit_pulse", 32'(hit_pulse[2]), 32'd1);
        check("hit_down", 32'(omole[2]), 32'd0);
        molehit = '0; misses = 0;
        step();
        check("hit_one_cycle", 32'(hit_pulse[2]), 32'd0);
        for (int k = 0; k < 100; k++) begin
            step();
            if (miss_pulse[2]) misses++;
        end
        check("hit_no_miss", 32'(misses), 32'd0);

        // Hit on the exact expiry cycle.
        do_reset();
        enable = 1'b1; difficulty = 2'd3; moletime = 3'd0; spawn = 8'h04;
        step();
        spawn = '0; found = 0;
        for (int k = 0; k < 600; k++) begin
            if (will_miss(2)) begin found = 1; break; end
            step();
        end
        check("expiry_reached", 32'(found), 32'd1);
        molehit = 8'h04;
        step();
        check("expiry_hit", 32'(hit_pulse[2]), 32'd1);
        check("expiry_no_miss", 32'(miss_pulse[2]), 32'd0);
        molehit = '0;
        step();
        check("expiry_no_late_miss", 32'(miss_pulse[2]), 32'd0);

        // All moles up, then disable.
        do_reset();
        enable = 1'b1; spawn = 8'hFF;
        step();
        check("all_up", 32'(omole), 32'hFF);
        step();
        check("all_count8", 32'(active_count), 32'd8);
        enable = 1'b0;
        step();
        check("dis_omole", 32'(omole), 32'd0);
        check("dis_pulses", 32'(hit_pulse | miss_pulse), 32'd0);
        step();
        check("dis_count0", 32'(active_count), 32'd0);

        // Held spawn through HIT, then re-request with new parameters.
        do_reset();
        enable = 1'b1; difficulty = 2'd0; moletime = 3'd7; spawn = 8'h20;
        step();
        molehit = 8'h20;
        step();
        molehit = '0;
        repeat (3) step();
        check("held_stays_down", 32'(omole[5]), 32'd0);
        spawn = '0;
        step();
        difficulty = 2'd3; moletime = 3'd0; spawn = 8'h20;
        step();
        check("respawn_up", 32'(omole[5]), 32'd1);
        found = 0;
        for (int k = 0; k < 600; k++) begin
            step();
            if (miss_pulse[5]) begin found = 1; break; end
        end
        check("respawn_fresh_timeout", 32'(found), 32'd1);

        // Asynchronous reset in the middle of UP.
        do_reset();
        enable = 1'b1; difficulty = 2'd0; moletime = 3'd0; spawn = 8'h01;
        repeat (10) step();
        rst_n = 1'b0;
        #1;
        check("arst_omole", 32'(omole), 32'd0);
        check("arst_miss", 32'(miss_pulse), 32'd0);
        check("arst_count", 32'(active_count), 32'd0);
        model_reset();
        #2;
        rst_n = 1'b1;
        difficulty = 2'd3;
        step();
        check("arst_new_request", 32'(omole[0]), 32'd1);
        found = 0;
        for (int k = 0; k < 600; k++) begin
            step();
            if (miss_pulse[0]) begin found = 1; break; end
        end
        check("arst_timeout", 32'(found), 32'd1);

        // Randomized traffic against the model.
        do_reset();
        for (int k = 0; k < 8000; k++) begin
            enable = ($urandom_range(0, 2999) != 0);
            difficulty = 2'($urandom_range(0, 3));
            moletime = 3'($urandom_range(0, 1));
            for (int b = 0; b < NM; b++) begin
                if ($urandom_range(0, 29) == 0) spawn[b] = ~spawn[b];
                molehit[b] = ($urandom_range(0, 1999) == 0);
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mole_array.md
MOLE_ARRAY -- requirements
Module: mole_array

Interface
REQ-001 Parameter NUM_MOLES, default 8, number of mole channels (1..16).
REQ-002 Parameter TICK_DIV, default 100000, CLK100MHZ cycles per 1 ms timer tick (>=2).
REQ-003 Parameter TIMER_W, default 14, width of each channel's down-counter.
REQ-004 CLK100MHZ  in  1  single system clock; all logic rising-edge.
REQ-005 CPU_RESETN  in  1  asynchronous active-low reset.
REQ-006 enable  in  1  game running; low forces all channels idle.
REQ-007 difficulty  in  2  speed level 0..3, sampled at spawn.
REQ-008 moletime  in  3  duration multiplier 0..7, sampled at spawn.
REQ-009 spawn  in  NUM_MOLES  per-channel level request to raise a mole.
REQ-010 molehit  in  NUM_MOLES  per-channel debounced hit, level or pulse.
REQ-011 omole  out  NUM_MOLES  registered mole-up indication.
REQ-012 hit_pulse  out  NUM_MOLES  one-cycle registered pulse per successful hit.
REQ-013 miss_pulse  out  NUM_MOLES  one-cycle registered pulse per timeout.
REQ-014 active_count  out  $clog2(NUM_MOLES+1)  registered popcount of omole.

Function
REQ-015 Shared prescaler counts 0..TICK_DIV-1 while enable=1, emits one-cycle tick on wrap, holds at 0 while enable=0.
REQ-016 Each channel SHALL run FSM IDLE, UP, HIT, MISS.
REQ-017 IDLE: omole=0; spawn[i]=1 with enable=1 at cycle t -> UP, omole[i]=1 at t+1.
REQ-018 On IDLE->UP, counter loads (moletime+1)*BASE_MS[difficulty], BASE_MS = {1000,750,500,250} for difficulty 0..3; later input changes ignored while UP.
REQ-019 UP: counter decrements by 1 on each tick; molehit/spawn changes otherwise no effect on count.
REQ-020 UP with molehit[i]=1 at cycle t -> HIT, omole[i]=0 and hit_pulse[i]=1 at t+1, pulse exactly one cycle.
REQ-021 UP with tick while counter==1 -> MISS, omole[i]=0 and miss_pulse[i]=1 next cycle, one cycle.
REQ-022 Simultaneous hit and expiry in the same cycle: hit wins; only hit_pulse asserts.
REQ-023 spawn[i] asserted while UP, HIT or MISS SHALL NOT restart or extend the mole.
REQ-024 HIT/MISS: omole=0; return to IDLE the cycle after spawn[i]=0 is sampled (mole stays down until a new request edge).
REQ-025 molehit[i] in IDLE, HIT or MISS SHALL be ignored, no pulse.
REQ-026 enable=0 sampled at cycle t: all channels IDLE, omole=0, no hit/miss pulses at t+1, counters cleared.
REQ-027 active_count equals popcount of omole, one cycle behind omole.
REQ-028 Counter arithmetic unsigned, TIMER_W bits; max load 8000 fits default width; no wrap below zero.

Reset
REQ-029 CPU_RESETN low SHALL asynchronously force every channel to IDLE, counters and prescaler to 0, and omole, hit_pulse, miss_pulse, active_count to 0.
REQ-030 Reset asserted mid-UP SHALL drop omole immediately with no miss_pulse; after release, a still-high spawn SHALL be treated as a new request.
REQ-031 Reset deassertion is synchronised externally; block requires no internal synchroniser.

Structure
REQ-032 Shared package mole_pkg holds the FSM state enum, BASE_MS table and default TIMER_W.
REQ-033 One sub-module mole_channel (FSM, counter, pulse regs) instantiated NUM_MOLES times by generate; prescaler and popcount live in mole_array.

Verification (TICK_DIV=2)
REQ-034 Reset, enable=1, difficulty=3, moletime=0, spawn[0] pulse -> omole[0] high next cycle, miss_pulse[0] after 250 ticks (500 cycles +/-2), omole[0] low.
REQ-035 Spawn[2] then molehit[2] 10 cycles later -> hit_pulse[2] one cycle, omole[2] low, no miss_pulse ever for that mole.
REQ-036 Hit asserted on the exact expiry cycle -> hit_pulse only, miss_pulse stays 0.
REQ-037 All 8 spawns high, then enable=0 -> active_count 8 then 0, omole all 0 next cycle, no pulses.
REQ-038 spawn[5] held high through HIT -> channel stays down; drop spawn 1 cycle, reassert -> new mole with freshly sampled difficulty/moletime.
REQ-039 CPU_RESETN pulsed low mid-UP -> omole 0 asynchronously, no miss_pulse, prescaler restarts from 0.
